// File: rtl/cdb_rs_bank.sv
// cdb_rs_bank: reservation-station bank that captures operands from the CDB and dispatches the lowest-index READY entry.
module cdb_rs_bank #(
  parameter int NUM_ENTRY  = 3,
  parameter int TAG_BASE   = 1,
  parameter int TAG_WIDTH  = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic                  issue_op,
  input  logic [DATA_WIDTH-1:0] issue_Vj,
  input  logic [DATA_WIDTH-1:0] issue_Vk,
  input  logic [TAG_WIDTH-1:0]  issue_Qj,
  input  logic [TAG_WIDTH-1:0]  issue_Qk,
  output logic [TAG_WIDTH-1:0]  issue_tag,
  input  logic                  cdb_valid,
  input  logic [TAG_WIDTH-1:0]  cdb_tag,
  input  logic [DATA_WIDTH-1:0] cdb_data,
  output logic                  disp_valid,
  input  logic                  disp_ready,
  output logic                  disp_op,
  output logic [DATA_WIDTH-1:0] disp_SrcA,
  output logic [DATA_WIDTH-1:0] disp_SrcB,
  output logic [TAG_WIDTH-1:0]  disp_tag,
  output logic [NUM_ENTRY-1:0]  busy
);
  localparam int IW = NUM_ENTRY > 1 ? $clog2(NUM_ENTRY) : 1;
  typedef enum logic [1:0] {S_FREE, S_WAIT, S_READY, S_EXEC} st_e;
  logic [NUM_ENTRY-1:0] rdy_w, op_w;
  logic [NUM_ENTRY-1:0][DATA_WIDTH-1:0] vj_w, vk_w;
  logic [IW-1:0] free_idx, rdy_idx;
  logic any_free, any_rdy, issue_fire, disp_fire, cdb_hit;
  assign cdb_hit    = cdb_valid && cdb_tag != '0;
  assign issue_fire = issue_valid && any_free;
  assign disp_fire  = any_rdy && disp_ready;
  for (genvar e = 0; e < NUM_ENTRY; e++) begin : g_ent
    st_e st_q, st_d;
    logic op_q, op_d, load, waitg, fwd_j, fwd_k;
    logic [DATA_WIDTH-1:0] vj_q, vj_d, vk_q, vk_d;
    logic [TAG_WIDTH-1:0] qj_q, qj_d, qk_q, qk_d, qsel_j, qsel_k;
    // A freshly issued entry sees the same CDB snoop as a waiting one, so a same-cycle producer is not missed.
    always_comb begin
      load   = st_q == S_FREE && issue_fire && free_idx == IW'(e);
      waitg  = st_q == S_WAIT;
      qsel_j = load ? issue_Qj : qj_q;
      qsel_k = load ? issue_Qk : qk_q;
      fwd_j  = (load || waitg) && cdb_hit && qsel_j == cdb_tag;
      fwd_k  = (load || waitg) && cdb_hit && qsel_k == cdb_tag;
      vj_d   = fwd_j ? cdb_data : load ? issue_Vj : vj_q;
      vk_d   = fwd_k ? cdb_data : load ? issue_Vk : vk_q;
      qj_d   = fwd_j ? '0 : qsel_j;
      qk_d   = fwd_k ? '0 : qsel_k;
      op_d   = load ? issue_op : op_q;
      st_d   = (load || waitg) ? ((qj_d == '0 && qk_d == '0) ? S_READY : S_WAIT)
             : (st_q == S_READY && disp_fire && rdy_idx == IW'(e)) ? S_EXEC
             : (st_q == S_EXEC && cdb_hit && cdb_tag == TAG_WIDTH'(TAG_BASE + e)) ? S_FREE
             : st_q;
    end
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        st_q <= S_FREE;
        op_q <= 1'b0;
        vj_q <= '0;
        vk_q <= '0;
        qj_q <= '0;
        qk_q <= '0;
      end else begin
        st_q <= st_d;
        op_q <= op_d;
        vj_q <= vj_d;
        vk_q <= vk_d;
        qj_q <= qj_d;
        qk_q <= qk_d;
      end
    end
    assign busy[e]  = st_q != S_FREE;
    assign rdy_w[e] = st_q == S_READY;
    assign op_w[e]  = op_q;
    assign vj_w[e]  = vj_q;
    assign vk_w[e]  = vk_q;
  end
  always_comb begin
    any_free = 1'b0;
    any_rdy  = 1'b0;
    free_idx = '0;
    rdy_idx  = '0;
    for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        any_free = 1'b1;
        free_idx = IW'(i);
      end
      if (rdy_w[i]) begin
        any_rdy = 1'b1;
        rdy_idx = IW'(i);
      end
    end
  end
  assign issue_ready = any_free;
  assign issue_tag   = any_free ? TAG_WIDTH'(TAG_BASE) + TAG_WIDTH'(free_idx) : '0;
  assign disp_valid  = any_rdy;
  assign disp_op     = any_rdy && op_w[rdy_idx];
  assign disp_SrcA   = any_rdy ? vj_w[rdy_idx] : '0;
  assign disp_SrcB   = any_rdy ? vk_w[rdy_idx] : '0;
  assign disp_tag    = any_rdy ? TAG_WIDTH'(TAG_BASE) + TAG_WIDTH'(rdy_idx) : '0;
endmodule

// File: tb/tb_cdb_rs_bank.sv
// tb_cdb_rs_bank: directed stimulus with a dispatch scoreboard checked by an independent monitor.
module tb_cdb_rs_bank;
  logic clk = 1'b0, reset = 1'b0;
  logic issue_valid = 1'b0, issue_ready, issue_op = 1'b0;
  logic [31:0] issue_Vj = '0, issue_Vk = '0;
  logic [3:0] issue_Qj = '0, issue_Qk = '0, issue_tag;
  logic cdb_valid = 1'b0;
  logic [3:0] cdb_tag = '0;
  logic [31:0] cdb_data = '0;
  logic disp_valid, disp_ready = 1'b0, disp_op;
  logic [31:0] disp_SrcA, disp_SrcB;
  logic [3:0] disp_tag;
  logic [2:0] busy;
  int errors = 0, checks = 0;
  logic [68:0] exp_q[$];

  cdb_rs_bank dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_Vj(issue_Vj), .issue_Vk(issue_Vk), .issue_Qj(issue_Qj), .issue_Qk(issue_Qk),
    .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_SrcA(disp_SrcA), .disp_SrcB(disp_SrcB), .disp_tag(disp_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic op, input logic [31:0] vj, input logic [31:0] vk,
                       input logic [3:0] qj, input logic [3:0] qk);
    issue_valid = 1'b1;
    issue_op = op;
    issue_Vj = vj;
    issue_Vk = vk;
    issue_Qj = qj;
    issue_Qk = qk;
    step();
    issue_valid = 1'b0;
  endtask

  task automatic bcast(input logic [3:0] tag, input logic [31:0] data);
    cdb_valid = 1'b1;
    cdb_tag = tag;
    cdb_data = data;
    step();
    cdb_valid = 1'b0;
  endtask

  // Monitor: every accepted dispatch must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && disp_valid && disp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL dispatch: unexpected tag=%0h A=%0h B=%0h", disp_tag, disp_SrcA, disp_SrcB);
        end else begin
          logic [68:0] e;
          e = exp_q.pop_front();
          if ({disp_tag, disp_op, disp_SrcA, disp_SrcB} !== e) begin
            errors++;
            $display("FAIL dispatch: got tag=%0h op=%0b A=%0h B=%0h expected tag=%0h op=%0b A=%0h B=%0h",
                     disp_tag, disp_op, disp_SrcA, disp_SrcB, e[68:65], e[64], e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_issue_tag", issue_tag, 1);
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_disp_tag", disp_tag, 0);
    chk("rst_disp_srca", disp_SrcA, 0);
    chk("rst_busy", busy, 0);
    step();
    reset = 1'b1;
    // Both operands ready: dispatch the cycle after issue.
    disp_ready = 1'b1;
    chk("t1_issue_tag", issue_tag, 1);
    exp_q.push_back({4'd1, 1'b0, 32'd5, 32'd7});
    issue(1'b0, 32'd5, 32'd7, 4'd0, 4'd0);
    chk("t1_disp_valid", disp_valid, 1);
    chk("t1_busy", busy, 3'b001);
    step();
    chk("t1_exec_busy", busy, 3'b001);
    chk("t1_exec_disp_valid", disp_valid, 0);
    bcast(4'd1, 32'd12);
    chk("t1_freed", busy, 3'b000);
    // Operand j waits on tag 2.
    exp_q.push_back({4'd1, 1'b1, 32'd10, 32'd3});
    issue(1'b1, 32'd0, 32'd3, 4'd2, 4'd0);
    chk("t2_wait_disp_valid", disp_valid, 0);
    chk("t2_wait_busy", busy, 3'b001);
    bcast(4'd2, 32'd10);
    chk("t2_cap_disp_valid", disp_valid, 1);
    chk("t2_cap_srca", disp_SrcA, 10);
    chk("t2_cap_srcb", disp_SrcB, 3);
    bcast(4'd1, 32'd99);
    chk("t2_ready_ignores_cdb", busy, 3'b001);
    chk("t2_exec_disp_valid", disp_valid, 0);
    bcast(4'd1, 32'd99);
    chk("t2_freed", busy, 3'b000);
    // Same-cycle forward at issue.
    exp_q.push_back({4'd1, 1'b0, 32'd9, 32'd6});
    cdb_valid = 1'b1;
    cdb_tag = 4'd4;
    cdb_data = 32'd9;
    issue(1'b0, 32'd0, 32'd6, 4'd4, 4'd0);
    cdb_valid = 1'b0;
    chk("t3_fwd_disp_valid", disp_valid, 1);
    chk("t3_fwd_srca", disp_SrcA, 9);
    step();
    bcast(4'd1, 32'd0);
    chk("t3_freed", busy, 3'b000);
    // Fill the bank; entry 0 waits on an out-of-range tag.
    disp_ready = 1'b0;
    chk("t4_tag1", issue_tag, 1);
    issue(1'b0, 32'd0, 32'd1, 4'd5, 4'd0);
    chk("t4_tag2", issue_tag, 2);
    issue(1'b1, 32'd8, 32'd3, 4'd0, 4'd0);
    chk("t4_tag3", issue_tag, 3);
    issue(1'b0, 32'd4, 32'd4, 4'd0, 4'd0);
    chk("t4_full_ready", issue_ready, 0);
    chk("t4_full_tag", issue_tag, 0);
    issue(1'b1, 32'd50, 32'd60, 4'd0, 4'd0);
    chk("t4_ignored_busy", busy, 3'b111);
    chk("t4_ignored_disp_tag", disp_tag, 2);
    exp_q.push_back({4'd2, 1'b1, 32'd8, 32'd3});
    disp_ready = 1'b1;
    step();
    disp_ready = 1'b0;
    chk("t4_next_disp_tag", disp_tag, 3);
    bcast(4'd2, 32'd11);
    chk("t4_busy_101", busy, 3'b101);
    chk("t4_reuse_tag", issue_tag, 2);
    chk("t4_reuse_ready", issue_ready, 1);
    issue(1'b0, 32'd20, 32'd22, 4'd0, 4'd0);
    chk("t4_refill_busy", busy, 3'b111);
    // Entry 0 wakes; stall holds the lowest entry.
    bcast(4'd5, 32'd7);
    for (int k = 0; k < 3; k++) begin
      chk("t5_hold_tag", disp_tag, 1);
      chk("t5_hold_srca", disp_SrcA, 7);
      step();
    end
    exp_q.push_back({4'd1, 1'b0, 32'd7, 32'd1});
    disp_ready = 1'b1;
    step();
    disp_ready = 1'b0;
    chk("t5_after_disp_tag", disp_tag, 2);
    reset = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 3'b000);
    chk("t5_rst_disp_valid", disp_valid, 0);
    chk("t5_rst_issue_tag", issue_tag, 1);
    chk("t5_rst_issue_ready", issue_ready, 1);
    reset = 1'b1;
    exp_q.push_back({4'd1, 1'b0, 32'd100, 32'd200});
    disp_ready = 1'b1;
    issue(1'b0, 32'd100, 32'd200, 4'd0, 4'd0);
    chk("t6_post_rst_valid", disp_valid, 1);
    chk("t6_post_rst_tag", disp_tag, 1);
    step();
    step();
    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cdb_rs_bank.md
CDB_RS_BANK -- requirements
Module: cdb_rs_bank

Interface
REQ-001 Parameter NUM_ENTRY, default 3, SHALL set the number of reservation-station entries.
REQ-002 Parameter TAG_BASE, default 1, SHALL set the tag of entry 0; entry i has tag TAG_BASE+i.
REQ-003 Parameter TAG_WIDTH, default 4, SHALL set the width of all tag ports; tag value 0 means "operand value present, no producer".
REQ-004 Parameter DATA_WIDTH, default 32, SHALL set the width of all operand and data ports.
REQ-005 The ports SHALL be:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- issue_valid  in  1  issue request.
- issue_ready  out  1  at least one entry FREE.
- issue_op  in  1  0=add, 1=sub.
- issue_Vj / issue_Vk  in  DATA_WIDTH  operand values, used when the matching Q is 0.
- issue_Qj / issue_Qk  in  TAG_WIDTH  producer tags.
- issue_tag  out  TAG_WIDTH  tag allocated to the current issue.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_WIDTH  CDB broadcast tag.
- cdb_data  in  DATA_WIDTH  CDB broadcast value.
- disp_valid  out  1  an entry is ready to execute.
- disp_ready  in  1  adder accepts the dispatch.
- disp_op  out  1  operation of the dispatched entry.
- disp_SrcA / disp_SrcB  out  DATA_WIDTH  Vj and Vk of the dispatched entry.
- disp_tag  out  TAG_WIDTH  tag of the dispatched entry.
- busy  out  NUM_ENTRY  bit i set when entry i is not FREE.

Function
REQ-006 Each entry SHALL hold op, Vj, Vk, Qj, Qk and a state in {FREE, WAIT, READY, EXEC}.
REQ-007 issue_ready and issue_tag SHALL be combinational from registered state: issue_tag = TAG_BASE + the index of the lowest FREE entry, or 0 when none is FREE.
REQ-008 An issue fires on issue_valid && issue_ready and SHALL write the lowest FREE entry on that clock edge.
REQ-009 issue_valid while issue_ready=0 SHALL be ignored with no state change.
REQ-010 On issue, if cdb_valid && cdb_tag!=0 && issue_Qx==cdb_tag, the entry SHALL store cdb_data as Vx and Qx=0 (same-cycle forward).
REQ-011 On issue, the new state SHALL be READY when both stored Q are 0, otherwise WAIT.
REQ-012 On every edge, each WAIT entry with Qx==cdb_tag (cdb_valid, cdb_tag!=0) SHALL capture cdb_data into Vx and clear Qx.
REQ-013 A WAIT entry SHALL move to READY on the edge where its last pending Q clears; both Q may clear on the same edge.
REQ-014 disp_valid SHALL be 1 when any entry is READY; disp_* SHALL present the lowest-index READY entry, combinationally from registered state.
REQ-015 On disp_valid && disp_ready, the presented entry SHALL move to EXEC; disp_* SHALL hold stable while disp_valid=1 and disp_ready=0, unless a lower-index entry becomes READY.
REQ-016 An EXEC entry whose tag equals cdb_tag with cdb_valid=1 SHALL move to FREE; a freed entry is reusable from the next cycle.
REQ-017 A CDB broadcast SHALL have no effect on entries in FREE or READY.
REQ-018 Latency: an issue with both operands ready SHALL give disp_valid=1 on the cycle after issue; operands captured from the CDB SHALL give disp_valid=1 on the cycle after the capture.
REQ-019 Tag 0 on the CDB SHALL be ignored, and cdb_tag outside this bank's range SHALL affect only operand capture.

Reset
REQ-020 reset=0 SHALL asynchronously set all entries FREE and clear all stored V/Q/op, including mid-operation.
REQ-021 During reset, outputs SHALL be: issue_ready=1, issue_tag=TAG_BASE, disp_valid=0, disp_*=0, busy=0.
REQ-022 The first issue SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-023 Issue add with Vj=5, Vk=7, Qj=Qk=0 -> issue_tag=1 → next cycle disp_valid=1, SrcA=5, SrcB=7, disp_tag=1, busy=001.
REQ-024 Issue with Qj=2, Qk=0, Vk=3; then CDB {tag 2, data 10} -> disp_valid=1 the cycle after the CDB, SrcA=10, SrcB=3.
REQ-025 Issue with Qj=4 in the same cycle as CDB {tag 4, data 9} -> entry READY immediately, next cycle SrcA=9.
REQ-026 Three issues -> tags 1, 2, 3 and issue_ready=0; a fourth issue is ignored. Dispatch tag 2, then CDB {tag 2} -> busy=101, and the next issue gets tag 2.
REQ-027 disp_ready=0 for 3 cycles with entries 0 and 2 READY -> disp_tag=1 held stable. Assert reset mid-run -> busy=000 and disp_valid=0 immediately.
